// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU requester-side driver.
package alu_pkg;

  // Interface widths of the combinational ALU.
  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int FLAG_W = 3;

  // Highest control code the ALU implements; anything above is refused.
  localparam logic [CTRL_W-1:0] MAX_OP = 4'd14;

  // Bit positions inside the ALU flag vector.
  localparam int FLAG_Z_BIT = 0;
  localparam int FLAG_N_BIT = 1;
  localparam int FLAG_C_BIT = 2;

  // Driver control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_settle_counter.sv
// Loadable down-counter used to time how long ALU inputs are held before
// the result is captured. Saturates at zero.
module alu_settle_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: load wins over decrement; hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/alu_driver.sv
// Requester-side driver for a combinational 32-bit ALU: accepts a request,
// holds operands for a settle time, captures result/flags and returns them.
module alu_driver #(
  parameter int                   DATA_W = alu_pkg::DATA_W,
  parameter int                   CTRL_W = alu_pkg::CTRL_W,
  parameter int                   FLAG_W = alu_pkg::FLAG_W,
  parameter logic [CTRL_W-1:0]    MAX_OP = alu_pkg::MAX_OP,
  parameter int                   SETTLE = 1,
  parameter int                   CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CTRL_W-1:0] req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_rega,
  output logic [DATA_W-1:0] alu_regb,
  output logic [CTRL_W-1:0] alu_ctrl_s,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  input  logic              sticky_clr,
  output logic [FLAG_W-1:0] sticky_flags,
  output logic [CNT_W-1:0]  op_count
);
  import alu_pkg::*;

  // SETTLE-1 must fit; a 1-bit counter covers SETTLE=1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e            state_d, state_q;
  logic [DATA_W-1:0] rega_d, rega_q, regb_d, regb_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] result_d, result_q;
  logic [FLAG_W-1:0] flags_d, flags_q;
  logic              err_d, err_q;
  logic [FLAG_W-1:0] sticky_d, sticky_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              req_ready_d, req_ready_q;
  logic              rsp_valid_d, rsp_valid_q;
  logic              cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [FLAG_W-1:0] sticky_base_s;

  alu_settle_counter #(.W(CW)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (CW'(SETTLE - 1)),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Next-state and datapath: everything holds unless the current state acts.
  always_comb begin
    state_d    = state_q;
    rega_d     = rega_q;
    regb_d     = regb_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    flags_d    = flags_q;
    err_d      = err_q;
    count_d    = count_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    // A clear in the capture cycle is applied before the new flags are ORed.
    sticky_base_s = sticky_clr ? {FLAG_W{1'b0}} : sticky_q;
    sticky_d      = sticky_base_s;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_op <= MAX_OP) begin
            rega_d     = req_a;
            regb_d     = req_b;
            ctrl_d     = req_op;
            cnt_load_s = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            result_d = {DATA_W{1'b0}};
            flags_d  = {FLAG_W{1'b0}};
            err_d    = 1'b1;
            state_d  = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cnt_zero_s) begin
          result_d = alu_result;
          flags_d  = alu_flags;
          err_d    = 1'b0;
          sticky_d = sticky_base_s | alu_flags;
          state_d  = ST_RESP;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          if (!err_q) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Handshake outputs are registered copies of the upcoming state.
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset drops any request or response in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rega_q      <= {DATA_W{1'b0}};
      regb_q      <= {DATA_W{1'b0}};
      ctrl_q      <= {CTRL_W{1'b0}};
      result_q    <= {DATA_W{1'b0}};
      flags_q     <= {FLAG_W{1'b0}};
      err_q       <= 1'b0;
      sticky_q    <= {FLAG_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rega_q      <= rega_d;
      regb_q      <= regb_d;
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign alu_rega     = rega_q;
  assign alu_regb     = regb_q;
  assign alu_ctrl_s   = ctrl_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = result_q;
  assign rsp_flags    = flags_q;
  assign rsp_err      = err_q;
  assign sticky_flags = sticky_q;
  assign op_count     = count_q;

endmodule
